serial_addsub_ctrl: RTL and testbench
=====================================

// Module: serial_addsub_ctrl
// PURPOSE
//  Bit-serial add/subtract sequencer: drives one 1-bit full-adder/full-subtractor
//  cell over WIDTH cycles, LSB first, to compute a+b or a-b on WIDTH-bit operands.
//  Trades latency for area vs. a ripple array. Sits between a requester issuing
//  start/op/operands and a consumer sampling result on done.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range >= 2
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      reset; synchronous, active-high
//  start   in   1      request; sampled only in IDLE
//  op      in   1      0 = add (a+b), 1 = subtract (a-b); sampled with start
//  a       in   WIDTH  operand A; sampled with start
//  b       in   WIDTH  operand B; sampled with start
//  busy    out  1      high in RUN and DONE
//  done    out  1      one-cycle pulse; result/cout valid while high and held after
//  result  out  WIDTH  sum or difference, modulo 2^WIDTH
//  cout    out  1      add: carry out of MSB; sub: borrow out of MSB (1 when a<b unsigned)
//  ovf     out  1      signed overflow; present only with SERIAL_ADDSUB_OVF_EN
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0;
//    bit counter=0; carry/borrow reg=0. Reset mid-operation aborts; no done pulse.
//  - States: IDLE -> RUN -> DONE -> IDLE (encoding 2 bits, see STRUCTURE).
//  - IDLE: on edge with start=1: latch a, b, op into shift regs; carry/borrow reg=0;
//    counter=0; go RUN. start=0: stay IDLE, outputs hold last result.
//  - RUN: each edge, cell consumes bit 0 of A/B shift regs and carry/borrow reg;
//    sum/diff bit shifts into result MSB (result right-shifts); A/B right-shift;
//    carry/borrow reg updates; counter++. On edge where counter==WIDTH-1: go DONE.
//  - Cell: add: s=x^y^c, c'=x&y | c&(x^y). sub: d=x^y^c, c'=~x&y | c&~(x^y).
//  - DONE: done=1 for exactly one cycle; cout=final carry/borrow reg; next edge IDLE.
//  - Latency: start accepted at edge k; done high in cycle after edge k+WIDTH.
//    Back-to-back: next start accepted earliest at edge k+WIDTH+2.
//  - start during RUN/DONE ignored (not queued); a/b/op changes in RUN ignored.
//  - result shows intermediate shift contents during RUN; valid only from done.
//  - Zero operands, a==b subtract: result=0, cout=0. 0-1: result=all ones, cout=1.
// CONFIGURATION
//  - SERIAL_ADDSUB_OVF_EN defined: ovf port exists; at DONE ovf = carry into MSB
//    XOR carry/borrow out of MSB (two's-complement overflow for op); reset 0; held
//    until next DONE.
//  - Not defined: no ovf port, no MSB-carry capture register; else identical.
// STRUCTURE
//  - Shared include serial_addsub_defs.vh: state encodings ST_IDLE=2'd0,
//    ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 unreachable, decodes to IDLE); OP_ADD=1'b0,
//    OP_SUB=1'b1.
//  - One sub-module: addsub_bit_cell (x, y, cin, op -> s, cout), purely
//    combinational, instantiated once; all sequencing stays in top.
//  - Counter width $clog2(WIDTH).
// TESTING (WIDTH=8 unless noted)
//  - add 0x35+0x4A, start at edge k -> done at k+8 cycle, result=0x7F, cout=0.
//  - add 0xFF+0x01 -> result=0x00, cout=1; busy high 9 cycles total (RUN+DONE).
//  - sub 0x10-0x20 -> result=0xF0, cout=1; sub 0x20-0x10 -> 0x10, cout=0.
//  - start pulsed with new operands during RUN -> ignored; original result,
//    exactly one done pulse; following start in IDLE processed normally.
//  - rst asserted at 4th RUN cycle -> next cycle busy=0, done=0, result=0, cout=0;
//    no done pulse; fresh op 0x01+0x01 -> 0x02.
//  - OVF_EN: 0x7F+0x01 -> 0x80, ovf=1; 0x80-0x01 -> 0x7F, ovf=1; 0x05+0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer.
package serial_addsub_ctrl_pkg;

  typedef logic [1:0] state_t;

  // 2'd3 is unreachable; every decoder treats it as IDLE.
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_bit_cell.sv
// One-bit full adder / full subtractor cell, purely combinational.
module addsub_bit_cell
  import serial_addsub_ctrl_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = x ^ y ^ cin;
    cout = 1'b0;
    case (op)
      OP_ADD:  cout = (x & y) | (cin & (x ^ y));
      default: cout = (~x & y) | (cin & ~(x ^ y)); // borrow out
    endcase
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer, LSB first, one cell reused over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, result_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             op_reg, carry_reg, cout_reg;
  logic             last_bit;
  logic             cell_s, cell_cout;

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  addsub_bit_cell u_cell (
    .x    (a_sh_reg[0]),
    .y    (b_sh_reg[0]),
    .cin  (carry_reg),
    .op   (op_reg),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = start ? ST_RUN : ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Result fills from the MSB end so that after WIDTH shifts bit 0 lands at LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      op_reg     <= 1'b0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          result_reg <= {cell_s, result_reg[WIDTH-1:1]};
          carry_reg  <= cell_cout;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (last_bit) cout_reg <= cell_cout;
        end
        ST_DONE: ;
        default: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            op_reg    <= op;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
          end
        end
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_reg;

  // On the last RUN edge carry_reg still holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst)                             ovf_reg <= 1'b0;
    else if (state_reg == ST_RUN && last_bit) ovf_reg <= carry_reg ^ cell_cout;
  end

  assign ovf = ovf_reg;
`endif

  assign result = result_reg;
  assign cout   = cout_reg;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized and directed bench for serial_addsub_ctrl against an arithmetic model.
// Define SERIAL_ADDSUB_OVF_EN to exercise the overflow output.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [W-1:0] a, b, result;
  logic         busy, done, cout, ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

`ifndef SERIAL_ADDSUB_OVF_EN
  assign ovf = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] t;
    if (o) t = {1'b0, x} - {1'b0, y};
    else   t = {1'b0, x} + {1'b0, y};
    r = t[W-1:0];
    c = t[W];
    if (o) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Issues one request and returns in the done cycle (or after a bounded wait).
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic v,
                       output int lat, output int bcnt);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = 1'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 4 * W) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    if (done) bcnt++;
    r = result; c = cout; v = ovf;
    $display("op=%0d a=%h b=%h -> result=%h cout=%0d ovf=%0d latency=%0d", o, x, y, r, c, v, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== '0)   begin failures++; $display("FAIL reset_result: got %h expected 00", result); end
    checks++; if (cout !== 1'b0)   begin failures++; $display("FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0)    begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic         t_op [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] t_a  [7] = '{8'h35, 8'hFF, 8'h10, 8'h20, 8'h00, 8'h5A, 8'h00};
    logic [W-1:0] t_b  [7] = '{8'h4A, 8'h01, 8'h20, 8'h10, 8'h00, 8'h5A, 8'h01};
    logic [W-1:0] t_r  [7] = '{8'h7F, 8'h00, 8'hF0, 8'h10, 8'h00, 8'h00, 8'hFF};
    logic         t_c  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] r;
    logic         c, v;
    int           lat, bcnt;
    for (int i = 0; i < 7; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], r, c, v, lat, bcnt);
      checks++; if (lat !== W)      begin failures++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, W); end
      checks++; if (bcnt !== W + 1) begin failures++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected %0d", i, bcnt, W + 1); end
      checks++; if (r !== t_r[i])   begin failures++; $display("FAIL dir_result[%0d]: got %h expected %h", i, r, t_r[i]); end
      checks++; if (c !== t_c[i])   begin failures++; $display("FAIL dir_cout[%0d]: got %b expected %b", i, c, t_c[i]); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL dir_done_pulse[%0d]: got done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, r, er;
    logic         o, c, v, ec, ev;
    int           lat, bcnt;
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom); x = W'($urandom); y = W'($urandom);
      if (i < 4) y = x;
      model(o, x, y, er, ec, ev);
      do_op(o, x, y, r, c, v, lat, bcnt);
      checks++; if (lat !== W) begin failures++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, W); end
      checks++; if (r !== er)  begin failures++; $display("FAIL rnd_result[%0d]: got %h expected %h", i, r, er); end
      checks++; if (c !== ec)  begin failures++; $display("FAIL rnd_cout[%0d]: got %b expected %b", i, c, ec); end
`ifdef SERIAL_ADDSUB_OVF_EN
      checks++; if (v !== ev)  begin failures++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", i, v, ev); end
`endif
      for (int g = 0; g < 1 + int'($urandom_range(2)); g++) tick();
      checks++; if (result !== er || cout !== ec) begin
        failures++; $display("FAIL rnd_hold[%0d]: got %h/%b expected %h/%b", i, result, cout, er, ec);
      end
    end
  endtask

  task automatic test_start_ignored();
    int           pulses = 0;
    logic [W-1:0] r = '0;
    logic         c = 1'b0, v;
    int           lat, bcnt;
    op = 1'b0; a = 8'h12; b = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    op = 1'b1; a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin pulses++; r = result; c = cout; end
      tick();
    end
    $display("start-in-run: pulses=%0d result=%h cout=%0d", pulses, r, c);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL ign_pulses: got %0d expected 1", pulses); end
    checks++; if (r !== 8'h46)  begin failures++; $display("FAIL ign_result: got %h expected 46", r); end
    checks++; if (c !== 1'b0)   begin failures++; $display("FAIL ign_cout: got %b expected 0", c); end
    do_op(1'b0, 8'h03, 8'h04, r, c, v, lat, bcnt);
    checks++; if (r !== 8'h07 || lat !== W) begin
      failures++; $display("FAIL ign_next_op: got %h lat=%0d expected 07 lat=%0d", r, lat, W);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int           pulses = 0;
    logic [W-1:0] r;
    logic         c, v;
    int           lat, bcnt;
    op = 1'b0; a = 8'h55; b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset mid-run: busy=%0d done=%0d result=%h cout=%0d", busy, done, result, cout);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mid_rst_flags: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++; if (result !== '0 || cout !== 1'b0) begin
      failures++; $display("FAIL mid_rst_data: got %h/%b expected 00/0", result, cout);
    end
    for (int i = 0; i < 2 * W; i++) begin
      if (done) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL mid_rst_no_done: got %0d expected 0", pulses); end
    do_op(1'b0, 8'h01, 8'h01, r, c, v, lat, bcnt);
    checks++; if (r !== 8'h02 || c !== 1'b0) begin
      failures++; $display("FAIL mid_rst_fresh: got %h/%b expected 02/0", r, c);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r;
    logic         c, v;
    int           lat, bcnt, n;
    do_op(1'b0, 8'h11, 8'h22, r, c, v, lat, bcnt);
    checks++; if (r !== 8'h33) begin failures++; $display("FAIL b2b_first: got %h expected 33", r); end
    op = 1'b1; a = 8'h50; b = 8'h20; start = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_done_ignores_start: got busy=%b expected 0", busy); end
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    start = 1'b0;
    n = 0;
    while (!done && n < 4 * W) begin tick(); n++; end
    $display("back-to-back second: result=%h cout=%0d latency=%0d", result, cout, n);
    checks++; if (n !== W) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", n, W); end
    checks++; if (result !== 8'h30 || cout !== 1'b0) begin
      failures++; $display("FAIL b2b_second: got %h/%b expected 30/0", result, cout);
    end
    tick();
  endtask

`ifdef SERIAL_ADDSUB_OVF_EN
  task automatic test_ovf();
    logic         t_op [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] t_a  [3] = '{8'h7F, 8'h80, 8'h05};
    logic [W-1:0] t_b  [3] = '{8'h01, 8'h01, 8'h03};
    logic [W-1:0] t_r  [3] = '{8'h80, 8'h7F, 8'h08};
    logic         t_v  [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] r;
    logic         c, v;
    int           lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], r, c, v, lat, bcnt);
      checks++; if (r !== t_r[i]) begin failures++; $display("FAIL ovf_result[%0d]: got %h expected %h", i, r, t_r[i]); end
      checks++; if (v !== t_v[i]) begin failures++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, v, t_v[i]); end
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADDSUB_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
